// File: rtl/rata_lmt_writer.sv
// LMT writer for the RATA monitor: flags CPU writes into AR/LMT and commits timestamps to LMT.
// Optional `RATA_DMA_MON_EN adds a DMA write port that feeds the same modification flags.
module rata_lmt_writer #(
   parameter int unsigned      ADDR_W   = 16,
   parameter int unsigned      DATA_W   = 16,
   parameter logic [ADDR_W-1:0] AR_BASE  = 16'h8000,
   parameter logic [ADDR_W-1:0] AR_END   = 16'hBFFF,
   parameter logic [ADDR_W-1:0] LMT_BASE = 16'h0100,
   localparam int unsigned     TS_W     = 2 * DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_wr_en,
   input  logic [ADDR_W-1:0] cpu_addr,
`ifdef RATA_DMA_MON_EN
   input  logic              dma_wr_en,
   input  logic [ADDR_W-1:0] dma_addr,
`endif
   input  logic              up_lmt,
   input  logic              mem_ready,
   output logic              mod_mem_ar,
   output logic              mod_mem_lmt,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              busy,
   output logic              lmt_done,
   output logic [TS_W-1:0]   lmt_value
);

   localparam logic [ADDR_W-1:0] LmtHiAddr = LMT_BASE + ADDR_W'(1);

   typedef enum logic [1:0] {StIdle, StWrLo, StWrHi} state_e;

   state_e              state_q;
   logic [TS_W-1:0]     ts_d, ts_q;
   logic [TS_W-1:0]     shadow_q;
   logic                pending_q;
   logic                up_lmt_q;
   logic                mod_ar_d, mod_ar_q;
   logic                mod_lmt_d, mod_lmt_q;
   logic                mem_wr_en_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic                lmt_done_q;
   logic [TS_W-1:0]     lmt_value_q;
   logic                req;

   // Only the external write ports are observed; our own mem_* writes never reach the flags.
   always_comb begin
      mod_ar_d  = cpu_wr_en && (cpu_addr >= AR_BASE) && (cpu_addr <= AR_END);
      mod_lmt_d = cpu_wr_en && ((cpu_addr == LMT_BASE) || (cpu_addr == LmtHiAddr));
`ifdef RATA_DMA_MON_EN
      mod_ar_d  = mod_ar_d || (dma_wr_en && (dma_addr >= AR_BASE) && (dma_addr <= AR_END));
      mod_lmt_d = mod_lmt_d ||
                  (dma_wr_en && ((dma_addr == LMT_BASE) || (dma_addr == LmtHiAddr)));
`endif
   end

   // Saturating so freshness stays monotonic.
   always_comb begin
      ts_d = ts_q;
      if (ts_q != {TS_W{1'b1}}) ts_d = ts_q + TS_W'(1);
   end

   assign req = up_lmt && !up_lmt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ts_q      <= '0;
         up_lmt_q  <= 1'b0;
         mod_ar_q  <= 1'b0;
         mod_lmt_q <= 1'b0;
      end else begin
         ts_q      <= ts_d;
         up_lmt_q  <= up_lmt;
         mod_ar_q  <= mod_ar_d;
         mod_lmt_q <= mod_lmt_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         shadow_q    <= '0;
         pending_q   <= 1'b0;
         mem_wr_en_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         lmt_done_q  <= 1'b0;
         lmt_value_q <= '0;
      end else begin
         lmt_done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req) begin
                  shadow_q    <= ts_q;
                  state_q     <= StWrLo;
                  mem_wr_en_q <= 1'b1;
                  mem_addr_q  <= LMT_BASE;
                  mem_wdata_q <= ts_q[DATA_W-1:0];
               end
            end
            StWrLo: begin
               if (req) pending_q <= 1'b1;
               if (mem_ready) begin
                  state_q     <= StWrHi;
                  mem_addr_q  <= LmtHiAddr;
                  mem_wdata_q <= shadow_q[TS_W-1:DATA_W];
               end
            end
            StWrHi: begin
               if (mem_ready) begin
                  lmt_value_q <= shadow_q;
                  lmt_done_q  <= 1'b1;
                  // A request landing on the final handshake still earns one re-run.
                  if (pending_q || req) begin
                     shadow_q    <= ts_q;
                     pending_q   <= 1'b0;
                     state_q     <= StWrLo;
                     mem_addr_q  <= LMT_BASE;
                     mem_wdata_q <= ts_q[DATA_W-1:0];
                  end else begin
                     state_q     <= StIdle;
                     mem_wr_en_q <= 1'b0;
                     mem_addr_q  <= '0;
                     mem_wdata_q <= '0;
                  end
               end else if (req) begin
                  pending_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= StIdle;
               mem_wr_en_q <= 1'b0;
               mem_addr_q  <= '0;
               mem_wdata_q <= '0;
            end
         endcase
      end
   end

   assign mod_mem_ar  = mod_ar_q;
   assign mod_mem_lmt = mod_lmt_q;
   assign mem_wr_en   = mem_wr_en_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign busy        = (state_q != StIdle);
   assign lmt_done    = lmt_done_q;
   assign lmt_value   = lmt_value_q;

endmodule

// File: tb/tb_rata_lmt_writer.sv
// Bench for rata_lmt_writer: flag vector table, LMT write scoreboard, and multi-cycle sequences.
// A second narrow instance (DATA_W=4) exercises timestamp saturation in reasonable time.
module tb_rata_lmt_writer;

   logic        clk = 1'b0;
   logic        rst, rst2;
   logic        cpu_wr_en, up_lmt, mem_ready;
   logic [15:0] cpu_addr;
   logic        mod_mem_ar, mod_mem_lmt, mem_wr_en, busy, lmt_done;
   logic [15:0] mem_addr, mem_wdata;
   logic [31:0] lmt_value;
`ifdef RATA_DMA_MON_EN
   logic        dma_wr_en;
   logic [15:0] dma_addr;
`endif

   logic        up2;
   logic        s_ar, s_lmt, s_wr_en, s_busy, s_done;
   logic [15:0] s_addr;
   logic [3:0]  s_wdata;
   logic [7:0]  s_value;
   logic        zero_bit = 1'b0;
   logic        one_bit  = 1'b1;
   logic [15:0] zero_addr = 16'h0000;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] tb_ts;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic        exp_ar;
      logic        exp_lmt;
   } flag_vec_t;
   flag_vec_t vecs[10];

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
   } wr_t;
   wr_t exp_q[$];
   wr_t mon_e;

   always #5 clk = ~clk;

   rata_lmt_writer dut (
      .clk         (clk),
      .reset       (rst),
      .cpu_wr_en   (cpu_wr_en),
      .cpu_addr    (cpu_addr),
`ifdef RATA_DMA_MON_EN
      .dma_wr_en   (dma_wr_en),
      .dma_addr    (dma_addr),
`endif
      .up_lmt      (up_lmt),
      .mem_ready   (mem_ready),
      .mod_mem_ar  (mod_mem_ar),
      .mod_mem_lmt (mod_mem_lmt),
      .mem_wr_en   (mem_wr_en),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .busy        (busy),
      .lmt_done    (lmt_done),
      .lmt_value   (lmt_value)
   );

   rata_lmt_writer #(.DATA_W(4)) dut_sat (
      .clk         (clk),
      .reset       (rst2),
      .cpu_wr_en   (zero_bit),
      .cpu_addr    (zero_addr),
`ifdef RATA_DMA_MON_EN
      .dma_wr_en   (zero_bit),
      .dma_addr    (zero_addr),
`endif
      .up_lmt      (up2),
      .mem_ready   (one_bit),
      .mod_mem_ar  (s_ar),
      .mod_mem_lmt (s_lmt),
      .mem_wr_en   (s_wr_en),
      .mem_addr    (s_addr),
      .mem_wdata   (s_wdata),
      .busy        (s_busy),
      .lmt_done    (s_done),
      .lmt_value   (s_value)
   );

   // Reference timestamp: counts cycles since reset release, saturating.
   always @(posedge clk or posedge rst) begin
      if (rst) tb_ts <= '0;
      else if (tb_ts != 32'hFFFF_FFFF) tb_ts <= tb_ts + 32'd1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_seq(input logic [31:0] ts);
      exp_q.push_back('{addr: 16'h0100, data: ts[15:0]});
      exp_q.push_back('{addr: 16'h0101, data: ts[31:16]});
   endtask

   // Polls for lmt_done (possibly already high), checks the value, then moves past the pulse.
   task automatic wait_done(input string name, input logic [31:0] exp);
      for (int i = 0; i < 40 && lmt_done !== 1'b1; i++) begin
         @(posedge clk);
         #1;
      end
      if (lmt_done !== 1'b1) chk({name, "_timeout"}, 64'(lmt_done), 64'd1);
      else chk(name, 64'(lmt_value), 64'(exp));
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every completed LMT handshake must match the next expected write.
   always @(negedge clk) begin
      #2;
      if (!rst && mem_wr_en && mem_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_lmt_write", 64'(mem_addr), 64'hFFFF_FFFF);
         end else begin
            mon_e = exp_q.pop_front();
            chk("lmt_wr_addr", 64'(mem_addr), 64'(mon_e.addr));
            chk("lmt_wr_data", 64'(mem_wdata), 64'(mon_e.data));
         end
      end
   end

   initial begin
      logic [31:0] t1, t2;
      vecs[0] = '{1'b1, 16'h8000, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 16'h8000, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 16'hC000, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 16'h0101, 1'b0, 1'b1};
      vecs[4] = '{1'b0, 16'h0101, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 16'h0100, 1'b0, 1'b1};
      vecs[6] = '{1'b1, 16'hBFFF, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 16'h7FFF, 1'b0, 1'b0};
      vecs[8] = '{1'b1, 16'h0102, 1'b0, 1'b0};
      vecs[9] = '{1'b1, 16'h00FF, 1'b0, 1'b0};

      rst = 1'b1; rst2 = 1'b1;
      cpu_wr_en = 1'b0; cpu_addr = '0; up_lmt = 1'b0; mem_ready = 1'b1; up2 = 1'b0;
`ifdef RATA_DMA_MON_EN
      dma_wr_en = 1'b0; dma_addr = '0;
`endif
      #12;
      chk("reset_ctl", 64'({mod_mem_ar, mod_mem_lmt, mem_wr_en, busy, lmt_done}), 64'd0);
      chk("reset_data", {mem_addr, mem_wdata, lmt_value}, 64'd0);
      @(negedge clk);
      rst = 1'b0; rst2 = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         cpu_wr_en = vecs[i].wr;
         cpu_addr  = vecs[i].addr;
         @(posedge clk);
         #1;
         chk($sformatf("flag_ar[%0d]", i), 64'(mod_mem_ar), 64'(vecs[i].exp_ar));
         chk($sformatf("flag_lmt[%0d]", i), 64'(mod_mem_lmt), 64'(vecs[i].exp_lmt));
      end
      @(negedge clk);
      cpu_wr_en = 1'b0;

      // Request at ts=37 with memory always ready.
      for (int i = 0; i < 100 && tb_ts != 32'd37; i++) @(negedge clk);
      up_lmt = 1'b1;
      push_seq(32'd37);
      @(posedge clk); #1;
      chk("lo_wr_en", 64'({mem_wr_en, busy}), 64'b11);
      chk("lo_addr", 64'(mem_addr), 64'h0100);
      @(posedge clk); #1;
      chk("hi_addr", 64'(mem_addr), 64'h0101);
      chk("self_write_no_flag", 64'({mod_mem_ar, mod_mem_lmt}), 64'd0);
      @(posedge clk); #1;
      chk("done_pulse", 64'({lmt_done, busy, mem_wr_en}), 64'b100);
      chk("value_37", 64'(lmt_value), 64'd37);
      @(posedge clk); #1;
      chk("done_one_cycle", 64'(lmt_done), 64'd0);
      @(negedge clk);
      up_lmt = 1'b0;

      // Stall in WR_LO: outputs must hold.
      @(negedge clk);
      mem_ready = 1'b0; up_lmt = 1'b1; t1 = tb_ts;
      push_seq(t1);
      @(negedge clk);
      up_lmt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("stall_hold", {15'd0, mem_wr_en, mem_addr, 16'd0, mem_wdata},
             {15'd0, 1'b1, 16'h0100, 16'd0, t1[15:0]});
      end
      @(negedge clk);
      mem_ready = 1'b1;
      wait_done("stall_value", t1);

      // Two more edges during a stalled WR_HI: exactly one re-run.
      @(negedge clk);
      up_lmt = 1'b1; t1 = tb_ts;
      push_seq(t1);
      @(negedge clk);
      up_lmt = 1'b0;
      @(negedge clk);
      mem_ready = 1'b0; up_lmt = 1'b1;
      @(negedge clk);
      up_lmt = 1'b0;
      @(negedge clk);
      up_lmt = 1'b1;
      @(negedge clk);
      mem_ready = 1'b1; t2 = tb_ts;
      push_seq(t2);
      wait_done("pend_first", t1);
      @(negedge clk);
      up_lmt = 1'b0;
      wait_done("pend_rerun", t2);
      repeat (6) @(negedge clk);
      chk("pend_no_third", 64'({busy, 31'(exp_q.size())}), 64'd0);

      // Edge coinciding with the final WR_HI handshake.
      @(negedge clk);
      up_lmt = 1'b1; t1 = tb_ts;
      push_seq(t1);
      @(negedge clk);
      up_lmt = 1'b0;
      @(negedge clk);
      up_lmt = 1'b1; t2 = tb_ts;
      push_seq(t2);
      @(negedge clk);
      up_lmt = 1'b0;
      wait_done("coin_first", t1);
      wait_done("coin_rerun", t2);
      repeat (4) @(negedge clk);
      chk("coin_idle", 64'({busy, 31'(exp_q.size())}), 64'd0);

`ifdef RATA_DMA_MON_EN
      @(negedge clk);
      dma_wr_en = 1'b1; dma_addr = 16'h0100;
      @(posedge clk); #1;
      chk("dma_lmt", 64'({mod_mem_ar, mod_mem_lmt}), 64'b01);
      @(negedge clk);
      dma_wr_en = 1'b1; dma_addr = 16'h9000; cpu_wr_en = 1'b1; cpu_addr = 16'hA000;
      @(posedge clk); #1;
      chk("dma_cpu_ar", 64'({mod_mem_ar, mod_mem_lmt}), 64'b10);
      @(negedge clk);
      dma_wr_en = 1'b0; cpu_wr_en = 1'b0;
      @(posedge clk); #1;
      chk("dma_cpu_single", 64'(mod_mem_ar), 64'd0);
`endif

      // Reset while stalled in WR_HI.
      @(negedge clk);
      up_lmt = 1'b1; mem_ready = 1'b1; t1 = tb_ts;
      push_seq(t1);
      @(negedge clk);
      up_lmt = 1'b0;
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk("pre_rst_hi", 64'({mem_wr_en, mem_addr}), 64'h1_0101);
      rst = 1'b1;
      #1;
      chk("rst_drops_wr_en", 64'({mem_wr_en, busy}), 64'd0);
      chk("rst_no_partial", 64'(lmt_value), 64'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_idle", 64'({mem_wr_en, busy, lmt_done}), 64'd0);

      // Saturation on the narrow instance (8-bit timestamp).
      repeat (300) @(negedge clk);
      up2 = 1'b1;
      repeat (4) @(negedge clk);
      chk("sat_value", 64'(s_value), 64'hFF);
      up2 = 1'b0;
      repeat (5) @(negedge clk);
      up2 = 1'b1;
      repeat (2) @(negedge clk);
      chk("sat_hi_word", 64'({s_wr_en, s_addr, s_wdata}), 64'h1_0101_F);
      repeat (2) @(negedge clk);
      chk("sat_no_wrap", 64'(s_value), 64'hFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
